// File: rtl/aes128_key_load_ctrl.sv
// AES-128 key load controller: round-robin arbitration of word-streamed keys
// into a zeroised staging buffer, with sticky lock and one-cycle commit strobe.
module aes128_key_load_ctrl #(
   parameter int NumReq = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [NumReq-1:0]     req_i,
   output logic [NumReq-1:0]     gnt_o,
   input  logic [NumReq-1:0]     wvalid_i,
   input  logic [NumReq*32-1:0]  wdata_i,
   output logic [NumReq-1:0]     wready_o,
   input  logic                  lock_i,
   output logic                  key_we_o,
   output logic [127:0]          key_o,
   output logic                  locked_o,
   output logic                  busy_o,
   output logic                  load_done_o,
   output logic                  abort_o
);

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StCollect = 2'd1;
   localparam logic [1:0] StCommit  = 2'd2;

   logic [1:0]   state_q, state_d;
   logic [1:0]   rr_q, rr_d;
   logic [1:0]   gidx_q, gidx_d;
   logic [1:0]   cnt_q, cnt_d;
   logic [127:0] key_q, key_d;
   logic         locked_q;

   logic [3:0]   req_pad;
   logic [3:0]   wvalid_pad;
   logic [127:0] wdata_pad;
   logic [31:0]  word;
   logic         in_collect;
   logic         abort;
   logic         win_vld;
   logic [1:0]   win;
   logic [1:0]   cand;

   // Indices live in 2 bits so NumReq up to 4 needs no width change.
   function automatic logic [1:0] wrap_idx(input logic [2:0] v);
      logic [2:0] s;
      s = v;
      if (s >= 3'(NumReq)) s = s - 3'(NumReq);
      return s[1:0];
   endfunction

   assign req_pad    = 4'(req_i);
   assign wvalid_pad = 4'(wvalid_i);
   assign wdata_pad  = 128'(wdata_i);
   assign word       = wdata_pad[{gidx_q, 5'b0} +: 32];
   assign in_collect = (state_q == StCollect);
   assign abort      = in_collect &
                       (~req_pad[gidx_q] | lock_i | locked_q);

   always_comb begin
      win     = rr_q;
      win_vld = 1'b0;
      cand    = '0;
      for (int k = 0; k < NumReq; k++) begin
         cand = wrap_idx({1'b0, rr_q} + 3'(k));
         if (!win_vld && req_pad[cand]) begin
            win     = cand;
            win_vld = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      gidx_d  = gidx_q;
      cnt_d   = cnt_q;
      key_d   = key_q;
      case (state_q)
         StIdle: begin
            if (!locked_q && win_vld) begin
               state_d = StCollect;
               gidx_d  = win;
               rr_d    = wrap_idx({1'b0, win} + 3'd1);
            end
         end
         StCollect: begin
            // Abort wins over a same-cycle word; that word is dropped.
            if (abort) begin
               state_d = StIdle;
               key_d   = '0;
               cnt_d   = '0;
            end else if (wvalid_pad[gidx_q]) begin
               key_d[{cnt_q, 5'b0} +: 32] = word;
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) state_d = StCommit;
            end
         end
         StCommit: begin
            state_d = StIdle;
            key_d   = '0;
            cnt_d   = '0;
         end
         default: begin
            state_d = StIdle;
            key_d   = '0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         rr_q     <= '0;
         gidx_q   <= '0;
         cnt_q    <= '0;
         key_q    <= '0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         gidx_q   <= gidx_d;
         cnt_q    <= cnt_d;
         key_q    <= key_d;
         if (lock_i) locked_q <= 1'b1;
      end
   end

   always_comb begin
      gnt_o = '0;
      for (int k = 0; k < NumReq; k++) begin
         gnt_o[k] = in_collect && (gidx_q == 2'(k));
      end
   end

   assign wready_o    = gnt_o;
   assign key_we_o    = (state_q == StCommit);
   assign load_done_o = (state_q == StCommit);
   assign busy_o      = (state_q != StIdle);
   assign abort_o     = abort;
   assign locked_o    = locked_q;
   assign key_o       = key_q;

endmodule

// File: tb/tb_aes128_key_load_ctrl.sv
// Directed + randomized bench for aes128_key_load_ctrl against a
// transaction-level model (round-robin pointer, expected key words).
module tb_aes128_key_load_ctrl;

   localparam int N = 2;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req, gnt, wvalid, wready;
   logic [N*32-1:0] wdata;
   logic           lock, key_we, locked, busy, done, abort;
   logic [127:0]   key;

   int n_assert = 0;
   int n_fail   = 0;
   int rr_m     = 0;

   always #5 clk = ~clk;

   aes128_key_load_ctrl #(.NumReq(N)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_i       (req),
      .gnt_o       (gnt),
      .wvalid_i    (wvalid),
      .wdata_i     (wdata),
      .wready_o    (wready),
      .lock_i      (lock),
      .key_we_o    (key_we),
      .key_o       (key),
      .locked_o    (locked),
      .busy_o      (busy),
      .load_done_o (done),
      .abort_o     (abort)
   );

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int pick(input logic [N-1:0] r);
      for (int k = 0; k < N; k++) begin
         if (r[(rr_m + k) % N]) return (rr_m + k) % N;
      end
      return 0;
   endfunction

   function automatic logic [127:0] low_words(input logic [127:0] k,
                                              input int n);
      logic [127:0] m;
      m = (128'(1) << (32 * n)) - 128'(1);
      return k & m;
   endfunction

   task automatic do_reset();
      rst_n  = 1'b0;
      req    = '0;
      wvalid = '0;
      lock   = 1'b0;
      tick();
      rst_n = 1'b1;
      rr_m  = 0;
   endtask

   task automatic drive_word(input int w, input logic [31:0] d,
                             input bit v);
      for (int k = 0; k < N; k++) begin
         wdata[k*32 +: 32] = $urandom;
         wvalid[k]         = 1'($urandom_range(0, 1));
      end
      wdata[w*32 +: 32] = d;
      wvalid[w]         = v;
   endtask

   task automatic grant(input logic [N-1:0] r, output int w);
      req    = r;
      wvalid = '0;
      #1;
      chk("idle_gnt", 128'(gnt), 128'(0));
      chk("idle_busy", 128'(busy), 128'(0));
      tick();
      w    = pick(r);
      rr_m = (w + 1) % N;
      chk("grant", 128'(gnt), 128'(1) << w);
      chk("busy_collect", 128'(busy), 128'(1));
   endtask

   // mode 0: continuous valid, 1: random stalls, 2: pattern 1,0,0,1,1,0,1
   task automatic feed(input int w, input logic [127:0] k,
                       input int nwords, input int mode);
      int n = 0;
      int cyc = 0;
      logic [6:0] pat = 7'b1011001;
      bit v;
      while (n < nwords && cyc < 64) begin
         if (mode == 0) v = 1'b1;
         else if (mode == 1) v = 1'($urandom_range(0, 1));
         else v = (cyc < 7) ? pat[cyc] : 1'b1;
         drive_word(w, k[n*32 +: 32], v);
         #1;
         chk("wready", 128'(wready), 128'(1) << w);
         chk("no_we_collect", 128'(key_we), 128'(0));
         chk("no_abort", 128'(abort), 128'(0));
         tick();
         if (v) n++;
         cyc++;
         chk("partial_key", key, low_words(k, n));
      end
      if (n < nwords) chk("feed_timeout", 128'(n), 128'(nwords));
   endtask

   task automatic commit(input logic [127:0] k, input bit lk);
      wvalid = '0;
      lock   = lk;
      #1;
      chk("commit_we", 128'(key_we), 128'(1));
      chk("commit_done", 128'(done), 128'(1));
      chk("commit_gnt", 128'(gnt), 128'(0));
      chk("commit_key", key, k);
      chk("commit_busy", 128'(busy), 128'(1));
      tick();
      lock = 1'b0;
      chk("post_key_zero", key, 128'(0));
      chk("post_we", 128'(key_we), 128'(0));
      chk("post_busy", 128'(busy), 128'(0));
      req = '0;
   endtask

   task automatic load(input logic [N-1:0] r, input logic [127:0] k,
                       input int mode, input bit lk, output int w);
      grant(r, w);
      feed(w, k, 4, mode);
      commit(k, lk);
   endtask

   task automatic rand_key(output logic [127:0] k);
      k = {$urandom, $urandom, $urandom, $urandom};
   endtask

   logic [127:0] kk;
   logic [N-1:0] rm;
   int w;

   initial begin
      rst_n  = 1'b0;
      req    = '0;
      wvalid = '0;
      wdata  = '0;
      lock   = 1'b0;
      #2;
      chk("rst_gnt", 128'(gnt), 128'(0));
      chk("rst_wready", 128'(wready), 128'(0));
      chk("rst_key", key, 128'(0));
      chk("rst_flags", 128'({key_we, locked, busy, done, abort}), 128'(0));
      tick();
      rst_n = 1'b1;

      // single load, fixed words
      kk = 128'h0C0D0E0F_08090A0B_04050607_00010203;
      load(2'b01, kk, 0, 1'b0, w);
      chk("single_winner", 128'(w), 128'(0));

      // round-robin with both requesting
      do_reset();
      for (int i = 0; i < 3; i++) begin
         rand_key(kk);
         load(2'b11, kk, 0, 1'b0, w);
         chk("rr_winner", 128'(w), 128'(i % 2));
      end

      // abort by request drop, without and with a coincident word
      for (int i = 0; i < 2; i++) begin
         rand_key(kk);
         rm = N'($urandom_range(1, (1 << N) - 1));
         grant(rm, w);
         feed(w, kk, 2, 0);
         req[w]    = 1'b0;
         wvalid[w] = 1'(i);
         #1;
         chk("abort_pulse", 128'(abort), 128'(1));
         chk("abort_no_we", 128'(key_we), 128'(0));
         tick();
         req = '0;
         chk("abort_key_zero", key, 128'(0));
         chk("abort_idle", 128'(busy), 128'(0));
         chk("abort_gnt", 128'(gnt), 128'(0));
         chk("abort_once", 128'(abort), 128'(0));
         rand_key(kk);
         load(2'b01, kk, 0, 1'b0, w);
      end

      // stalls: fixed pattern then random
      rand_key(kk);
      load(2'b10, kk, 2, 1'b0, w);
      for (int i = 0; i < 3; i++) begin
         rand_key(kk);
         rm = N'($urandom_range(1, (1 << N) - 1));
         load(rm, kk, 1, 1'b0, w);
      end

      // lock during COLLECT aborts
      rand_key(kk);
      grant(2'b01, w);
      feed(w, kk, 1, 0);
      lock      = 1'b1;
      wvalid[w] = 1'b1;
      #1;
      chk("lock_abort", 128'(abort), 128'(1));
      tick();
      lock = 1'b0;
      req  = 2'b11;
      chk("lock_set", 128'(locked), 128'(1));
      chk("lock_key_zero", key, 128'(0));
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("locked_no_gnt", 128'({gnt, busy}), 128'(0));
      end
      do_reset();
      chk("lock_cleared", 128'(locked), 128'(0));

      // lock during COMMIT still commits, then blocks grants
      rand_key(kk);
      load(2'b11, kk, 0, 1'b1, w);
      chk("lock_commit_set", 128'(locked), 128'(1));
      req = 2'b01;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("locked_no_gnt2", 128'({gnt, busy}), 128'(0));
         chk("locked_stays", 128'(locked), 128'(1));
      end
      do_reset();

      // async reset mid-load
      rand_key(kk);
      grant(2'b10, w);
      feed(w, kk, 2, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_gnt", 128'({gnt, wready}), 128'(0));
      chk("arst_key", key, 128'(0));
      chk("arst_flags", 128'({key_we, locked, busy, done, abort}), 128'(0));
      tick();
      rst_n  = 1'b1;
      rr_m   = 0;
      req    = '0;
      wvalid = '1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("arst_no_we", 128'({key_we, busy}), 128'(0));
      end
      rand_key(kk);
      load(2'b11, kk, 1, 1'b0, w);
      chk("arst_rr_reset", 128'(w), 128'(0));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/aes128_key_load_ctrl.md
# aes128_key_load_ctrl

Arbitrated key-loading controller in front of the AES-128 key register. It shares the single key write port between `NumReq` requesters (e.g. host CSR path, secure key bus). Each requester streams a key as four 32-bit words over a valid/ready handshake, and the block commits the assembled 128-bit key with a one-cycle write strobe. A sticky lock freezes the key until reset, and the staging buffer is zeroised after every commit or abort.

## Interface
- `NumReq`, 2: number of requesters; legal range 2..4.
- `clk_i` input 1: clock.
- `rst_ni` input 1: asynchronous active-low reset.
- `req_i` input NumReq: per-requester load request. Must be held high for the whole load.
- `gnt_o` output NumReq: one-hot grant. At most one bit is high.
- `wvalid_i` input NumReq: per-requester key word valid.
- `wdata_i` input NumReq×32: per-requester key word.
- `wready_o` output NumReq: per-requester word ready. Equals `gnt_o` while in COLLECT.
- `lock_i` input 1: sets the sticky lock. Only `rst_ni` clears it.
- `key_we_o` output 1: one-cycle write strobe to the key register.
- `key_o` output 128: staging buffer contents.
- `locked_o` output 1: lock status.
- `busy_o` output 1: high when the FSM is not IDLE.
- `load_done_o` output 1: one-cycle pulse, coincident with `key_we_o`.
- `abort_o` output 1: one-cycle pulse when a partial load is discarded.

## Operation
- FSM states: IDLE, COLLECT, COMMIT.
- IDLE:
  - If `locked_o`=0 and any `req_i` is high, pick a winner by round-robin starting at pointer `rr`.
  - Register the grant and go to COLLECT.
  - Set `rr` = (winner+1) mod NumReq.
- COLLECT, granted index g:
  - `gnt_o[g]`=1 and `wready_o[g]`=1.
  - A handshake is `wvalid_i[g]` & `wready_o[g]` & `req_i[g]`.
  - Word n goes to `key_o[32n+31:32n]`; word 0 is the LSW. 2-bit counter `cnt` increments per handshake.
  - On the handshake with `cnt`=3, go to COMMIT.
- COMMIT: `key_we_o`=1, `load_done_o`=1, then go to IDLE.
  - On the next edge, `key_o` clears to 0 and `cnt` clears to 0.
- Abort: taken in COLLECT when `req_i[g]`=0, or when `lock_i`=1 or `locked_o`=1.
  - Response: `abort_o` pulses, `key_o` clears to 0, `cnt` clears to 0, go to IDLE.
  - No `key_we_o` is issued.
  - Abort has priority over a same-cycle word handshake; that word is dropped.
- Lock: `lock_i` high in any cycle sets `locked_o` on the next edge.
  - In COMMIT, lock does not cancel the commit; the commit completes.
  - While locked, no grants are issued.
- Words on non-granted requesters are ignored; their `wready_o` is 0.
- The counter never wraps inside a load, because the 4th handshake always exits COLLECT.

## Timing
- Reset values: state IDLE, `rr`=0, `cnt`=0, `key_o`=0. All 1-bit outputs and all `gnt_o`/`wready_o` bits are 0.
- Reset mid-load discards the partial key and issues no strobe.
- Grant latency: `req_i` sampled high in IDLE at cycle t gives `gnt_o` high at t+1.
- Best-case load, with `wvalid_i` high continuously:
  - Words are accepted at t+1..t+4.
  - COMMIT is at t+5: `key_we_o`=1, `gnt_o`=0.
  - The key register captures the key at the end of t+5.
  - IDLE at t+6, so the next grant is no earlier than t+7.
- `wvalid_i` may stall indefinitely in COLLECT; there is no timeout.
- `abort_o` is high in the cycle the abort condition is seen in COLLECT. `gnt_o` is 0 from the next cycle.
- `busy_o` is high from t+1 through the COMMIT cycle (or the abort cycle) inclusive.

## Test plan
- **Single load:**
  - Stimulus: reset, then req0 with words 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F back-to-back.
  - Required: gnt0 at t+1; `key_we_o` at t+5 with `key_o`=0x0C0D0E0F_08090A0B_04050607_00010203; `key_o`=0 at t+6.
- **Round-robin:**
  - Stimulus: req0 and req1 both held high over two full loads.
  - Required: first grant goes to 0, second to 1. A third load with both requesting grants 0.
- **Abort:**
  - Stimulus: req0 drops after 2 words; also repeat with the drop coinciding with a `wvalid_i` handshake.
  - Required: `abort_o` pulses, no `key_we_o`, `key_o`=0, IDLE next cycle.
- **Stall:**
  - Stimulus: `wvalid_i` toggles 1,0,0,1,1,0,1.
  - Required: exactly 4 words captured in order, then a single `key_we_o`.
- **Lock:**
  - Stimulus: `lock_i` in COLLECT; then `lock_i` in COMMIT; then a new request.
  - Required: the COLLECT case aborts. The COMMIT case still strobes. The new request gets no grant; `locked_o`=1 until `rst_ni`.
- **Async reset mid-load:**
  - Stimulus: assert `rst_ni` low after word 2.
  - Required: all outputs 0 immediately; no strobe after release.
